// File: rtl/unpack_blk_to_stream_addr_gen_if.sv
// Bundle for the descriptor, multiplier and address-stream channels.
// master: address generator side; slave: surrounding system side.
interface unpack_blk_to_stream_addr_gen_if #(
   parameter int ADDR_W   = 64,
   parameter int ROW_W    = 32,
   parameter int STRIDE_W = 34,
   parameter int MUL_W    = 65
);
   logic                desc_valid;
   logic                desc_ready;
   logic [ADDR_W-1:0]   desc_base;
   logic [ROW_W-1:0]    desc_rows;
   logic [STRIDE_W-1:0] desc_stride;

   logic                mul_ce;
   logic [ROW_W-1:0]    mul_din0;
   logic [STRIDE_W-1:0] mul_din1;
   logic [MUL_W-1:0]    mul_dout;

   logic                addr_valid;
   logic                addr_ready;
   logic [ADDR_W-1:0]   addr_data;
   logic                addr_last;

   modport master (
      input  desc_valid, desc_base, desc_rows, desc_stride,
      output desc_ready,
      output mul_ce, mul_din0, mul_din1,
      input  mul_dout,
      output addr_valid, addr_data, addr_last,
      input  addr_ready
   );

   modport slave (
      output desc_valid, desc_base, desc_rows, desc_stride,
      input  desc_ready,
      input  mul_ce, mul_din0, mul_din1,
      output mul_dout,
      input  addr_valid, addr_data, addr_last,
      output addr_ready
   );
endinterface

// File: rtl/unpack_blk_to_stream_addr_gen.sv
// Turns a (base, rows, stride) descriptor into a stream of row addresses
// using an external one-stage multiplier for row*stride.
module unpack_blk_to_stream_addr_gen #(
   parameter int ADDR_W   = 64,
   parameter int ROW_W    = 32,
   parameter int STRIDE_W = 34,
   parameter int MUL_W    = 65
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   output logic busy,
   unpack_blk_to_stream_addr_gen_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base_q;
   logic [ROW_W-1:0]    rows_q;
   logic [STRIDE_W-1:0] stride_q;
   logic [ROW_W-1:0]    row;
   logic                p_v;
   logic                p_last;

   logic                adv;
   logic                hs;
   logic                last_row;
   logic                last_acc;
   logic [ROW_W-1:0]    rows_m;
   logic [ADDR_W-1:0]   prod_ext;

   // Row count MSB is a sign bit of the multiplier operand; force it clear.
   assign rows_m   = {1'b0, bus.desc_rows[ROW_W-2:0]};
   assign adv      = !bus.addr_valid || bus.addr_ready;
   assign hs       = bus.desc_valid && bus.desc_ready;
   assign last_row = (row == rows_q - ROW_W'(1));
   assign last_acc = bus.addr_valid && bus.addr_ready && bus.addr_last;
   assign prod_ext = ADDR_W'(signed'(bus.mul_dout));

   assign bus.desc_ready = (state == IDLE) && ap_rst_n;
   assign bus.mul_ce     = adv;
   assign bus.mul_din0   = {1'b0, row[ROW_W-2:0]};
   assign bus.mul_din1   = stride_q;
   assign busy           = (state != IDLE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state          <= IDLE;
         base_q         <= '0;
         rows_q         <= '0;
         stride_q       <= '0;
         row            <= '0;
         p_v            <= 1'b0;
         p_last         <= 1'b0;
         bus.addr_valid <= 1'b0;
         bus.addr_last  <= 1'b0;
         bus.addr_data  <= '0;
      end else begin
         if (adv) begin
            bus.addr_valid <= p_v;
            bus.addr_last  <= p_last;
            if (p_v) bus.addr_data <= base_q + prod_ext;
         end
         unique case (state)
            IDLE: begin
               if (adv) p_v <= 1'b0;
               if (hs) begin
                  base_q   <= bus.desc_base;
                  rows_q   <= rows_m;
                  stride_q <= bus.desc_stride;
                  row      <= '0;
                  if (rows_m != '0) state <= RUN;
               end
            end
            RUN: begin
               if (adv) begin
                  p_v    <= 1'b1;
                  p_last <= last_row;
                  row    <= row + ROW_W'(1);
                  if (last_row) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (adv) p_v <= 1'b0;
               if (last_acc) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
